mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single unified memory port between instruction fetch and the memory-access stage. Data accesses have priority; a streak counter guarantees fetch forward progress. The block tracks in-flight reads in a latency-matched tag pipeline so that each returned word is steered to the requester that issued it. It sits between the fetch/memory-access stages and the memory, and replaces their private memory ports.

---
 rtl/mem_port_arbiter_if.sv | 36 +++
 rtl/mem_port_arbiter.sv | 76 +++++++
 tb/tb_mem_port_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Shared-memory-port bundle: fetch requester, data requester and the unified memory port.
// The arbiter uses the slave view; the environment (requesters plus memory) uses the master view.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvld;
  logic [31:0] if_rdata;

  logic        d_req;
  logic [31:0] d_addr;
  logic [3:0]  d_we;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvld;
  logic [31:0] d_rdata;

  logic        m_req;
  logic [31:0] m_addr;
  logic [3:0]  m_we;
  logic [31:0] m_wdata;
  logic        m_ready;
  logic [31:0] m_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_addr, d_we, d_wdata, m_ready, m_rdata,
    output if_gnt, if_rvld, if_rdata, d_gnt, d_rvld, d_rdata,
    output m_req, m_addr, m_we, m_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_addr, d_we, d_wdata, m_ready, m_rdata,
    input  if_gnt, if_rvld, if_rdata, d_gnt, d_rvld, d_rdata,
    input  m_req, m_addr, m_we, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Data-priority arbiter for the unified memory port, with a fetch-starvation streak limit
// and a latency-matched tag pipeline that steers each read response to its issuer.
module mem_port_arbiter #(
  parameter int RD_LAT      = 1,
  parameter int MAX_DSTREAK = 4
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] STREAK_LIM = 4'(MAX_DSTREAK);

  logic [3:0]        streak_q, streak_d;
  logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [RD_LAT-1:0] tag_own_q, tag_own_d;

  logic fetch_starved;
  logic d_win;
  logic f_win;
  logic rd_issue;

  // Grants are gated by rst so nothing leaves the block while reset is held.
  always_comb begin
    fetch_starved = bus.if_req && (streak_q == STREAK_LIM);
    d_win         = rst && bus.m_ready && bus.d_req && !fetch_starved;
    f_win         = rst && bus.m_ready && bus.if_req && !d_win;
    rd_issue      = f_win || (d_win && (bus.d_we == 4'h0));
  end

  always_comb begin
    streak_d = streak_q;
    if (!bus.if_req || f_win) begin
      streak_d = 4'h0;
    end else if (d_win && (streak_q < STREAK_LIM)) begin
      streak_d = streak_q + 4'h1;
    end
  end

  // Owner bit: 1 = data, 0 = fetch. Writes enter as bubbles.
  always_comb begin
    tag_vld_d    = '0;
    tag_own_d    = '0;
    tag_vld_d[0] = rd_issue;
    tag_own_d[0] = d_win;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_own_d[i] = tag_own_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak_q  <= 4'h0;
      tag_vld_q <= '0;
      tag_own_q <= '0;
    end else begin
      streak_q  <= streak_d;
      tag_vld_q <= tag_vld_d;
      tag_own_q <= tag_own_d;
    end
  end

  assign bus.if_gnt  = f_win;
  assign bus.d_gnt   = d_win;
  assign bus.m_req   = f_win || d_win;
  assign bus.m_addr  = d_win ? bus.d_addr  : (f_win ? bus.if_addr : 32'h0);
  assign bus.m_we    = d_win ? bus.d_we    : 4'h0;
  assign bus.m_wdata = d_win ? bus.d_wdata : 32'h0;

  assign bus.if_rvld  = tag_vld_q[RD_LAT-1] && !tag_own_q[RD_LAT-1];
  assign bus.d_rvld   = tag_vld_q[RD_LAT-1] &&  tag_own_q[RD_LAT-1];
  assign bus.if_rdata = bus.m_rdata;
  assign bus.d_rdata  = bus.m_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Table-driven bench for mem_port_arbiter with a read-response scoreboard and
// hand-written sequences for reset, backpressure and reset-while-in-flight.
module tb_mem_port_arbiter;

  localparam int RD_LAT      = 2;
  localparam int MAX_DSTREAK = 4;

  logic clk;
  logic rst;
  int   cyc;
  int   n_total;
  int   n_pass;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.RD_LAT(RD_LAT), .MAX_DSTREAK(MAX_DSTREAK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ir;
    logic       dr;
    logic       rdy;
    logic [3:0] dwe;
    logic       e_if;
    logic       e_d;
  } vec_t;

  typedef struct {
    int   due;
    logic own_d;
  } exp_rd_t;

  vec_t    vecs[16];
  exp_rd_t sb[$];

  function automatic logic [31:0] pat(input int c);
    return 32'hA5A5_0000 ^ 32'(c);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
  endtask

  // One clock cycle: drive, predict, compare at the falling edge, advance.
  task automatic drive_cycle(input string tag,
                             input logic ir, input logic [31:0] ia,
                             input logic dr, input logic [31:0] da,
                             input logic [3:0] dwe, input logic [31:0] dwd,
                             input logic rdy, input logic [31:0] rdata,
                             input logic e_if, input logic e_d);
    logic        ev_if, ev_d;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_we;
    bus.if_req  = ir;
    bus.if_addr = ia;
    bus.d_req   = dr;
    bus.d_addr  = da;
    bus.d_we    = dwe;
    bus.d_wdata = dwd;
    bus.m_ready = rdy;
    bus.m_rdata = rdata;
    e_addr  = e_d ? da  : (e_if ? ia : 32'h0);
    e_we    = e_d ? dwe : 4'h0;
    e_wdata = e_d ? dwd : 32'h0;
    if (e_if || (e_d && dwe == 4'h0)) sb.push_back('{cyc + RD_LAT, e_d});
    @(negedge clk);
    chk({tag, ".if_gnt"},  32'(bus.if_gnt), 32'(e_if));
    chk({tag, ".d_gnt"},   32'(bus.d_gnt),  32'(e_d));
    chk({tag, ".m_req"},   32'(bus.m_req),  32'(e_if | e_d));
    chk({tag, ".m_addr"},  bus.m_addr,  e_addr);
    chk({tag, ".m_we"},    32'(bus.m_we), 32'(e_we));
    chk({tag, ".m_wdata"}, bus.m_wdata, e_wdata);
    ev_if = (sb.size() > 0) && (sb[0].due == cyc) && !sb[0].own_d;
    ev_d  = (sb.size() > 0) && (sb[0].due == cyc) &&  sb[0].own_d;
    chk({tag, ".if_rvld"}, 32'(bus.if_rvld), 32'(ev_if));
    chk({tag, ".d_rvld"},  32'(bus.d_rvld),  32'(ev_d));
    chk({tag, ".if_rdata"}, bus.if_rdata, rdata);
    chk({tag, ".d_rdata"},  bus.d_rdata,  rdata);
    if (ev_if || ev_d) void'(sb.pop_front());
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input string tag);
    drive_cycle(tag, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, pat(cyc), 1'b0, 1'b0);
  endtask

  // Requester rule: a request may not drop before it is granted.
  logic if_pend_m, d_pend_m;
  initial begin
    if_pend_m = 1'b0;
    d_pend_m  = 1'b0;
  end
  always @(posedge clk) begin
    if (rst && ((if_pend_m && !bus.if_req) || (d_pend_m && !bus.d_req))) begin
      n_total++;
      $display("FAIL req_drop cyc=%0d if_req=%b d_req=%b", cyc, bus.if_req, bus.d_req);
    end
    if_pend_m = rst && bus.if_req && !bus.if_gnt;
    d_pend_m  = rst && bus.d_req  && !bus.d_gnt;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 4'h3, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0};

    n_total = 0;
    n_pass  = 0;
    cyc     = 0;
    rst     = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.d_req  = 1'b0; bus.d_addr  = 32'h0; bus.d_we = 4'h0; bus.d_wdata = 32'h0;
    bus.m_ready = 1'b1; bus.m_rdata = 32'h0;
    @(posedge clk);
    #1;

    // Reset held with both requesters active: everything quiet.
    for (int i = 0; i < 2; i++)
      drive_cycle("rst_hold", 1'b1, 32'h10, 1'b1, 32'h20, 4'h0, 32'h0, 1'b1, pat(cyc), 1'b0, 1'b0);
    rst = 1'b1;
    drive_cycle("rst_rel", 1'b1, 32'h10, 1'b1, 32'h20, 4'h0, 32'h0, 1'b1, pat(cyc), 1'b0, 1'b1);
    drive_cycle("rst_rel_f", 1'b1, 32'h10, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, pat(cyc), 1'b1, 1'b0);

    for (int i = 0; i < 16; i++)
      drive_cycle($sformatf("vec%0d", i),
                  vecs[i].ir, 32'h1000 + 32'(i) * 4, vecs[i].dr, 32'h2000 + 32'(i) * 4,
                  vecs[i].dwe, 32'h5000_0000 + 32'(i), vecs[i].rdy, pat(cyc),
                  vecs[i].e_if, vecs[i].e_d);

    // Solo fetch, memory returns DEADBEEF RD_LAT cycles later.
    drive_cycle("solo_f", 1'b1, 32'h100, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, pat(cyc), 1'b1, 1'b0);
    idle("solo_w");
    drive_cycle("solo_ret", 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // Partial write followed by a fetch read: only the fetch returns.
    drive_cycle("wr", 1'b0, 32'h0, 1'b1, 32'h40, 4'b0011, 32'h1234_5678, 1'b1, pat(cyc), 1'b0, 1'b1);
    drive_cycle("wr_f", 1'b1, 32'h200, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, pat(cyc), 1'b1, 1'b0);
    idle("wr_i0");
    idle("wr_i1");

    // Backpressure with reads in flight; streak must survive the stall.
    drive_cycle("bp_d1", 1'b1, 32'h300, 1'b1, 32'h80, 4'h0, 32'h0, 1'b1, pat(cyc), 1'b0, 1'b1);
    drive_cycle("bp_d2", 1'b1, 32'h300, 1'b1, 32'h84, 4'h0, 32'h0, 1'b1, pat(cyc), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      drive_cycle("bp_stall", 1'b1, 32'h300, 1'b1, 32'h88, 4'h0, 32'h0, 1'b0, pat(cyc), 1'b0, 1'b0);
    drive_cycle("bp_d3", 1'b1, 32'h300, 1'b1, 32'h88, 4'h0, 32'h0, 1'b1, pat(cyc), 1'b0, 1'b1);
    drive_cycle("bp_d4", 1'b1, 32'h300, 1'b1, 32'h8C, 4'h0, 32'h0, 1'b1, pat(cyc), 1'b0, 1'b1);
    drive_cycle("bp_f",  1'b1, 32'h300, 1'b1, 32'h90, 4'h0, 32'h0, 1'b1, pat(cyc), 1'b1, 1'b0);
    drive_cycle("bp_d5", 1'b0, 32'h0,   1'b1, 32'h90, 4'h0, 32'h0, 1'b1, pat(cyc), 1'b0, 1'b1);
    idle("bp_i0");
    idle("bp_i1");

    // Reset while two reads are in flight: their responses are discarded.
    drive_cycle("mf_f", 1'b1, 32'h400, 1'b0, 32'h0,   4'h0, 32'h0, 1'b1, pat(cyc), 1'b1, 1'b0);
    drive_cycle("mf_d", 1'b0, 32'h0,   1'b1, 32'hA0,  4'h0, 32'h0, 1'b1, pat(cyc), 1'b0, 1'b1);
    rst = 1'b0;
    sb.delete();
    idle("mf_rst0");
    idle("mf_rst1");
    rst = 1'b1;
    for (int i = 0; i < 4; i++) idle("mf_after");

    for (int i = 0; i < RD_LAT + 2; i++) idle("drain");
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
